// File: rtl/reversalmb_module.sv
// reversalmb_module: requester-side sequencer for the MBINIT.REVERSALMB step.
// It runs the init / clear-error / pattern / result / done handshake with the
// link partner. It judges lane order from the partner's per-lane result and
// retries once with lane reversal applied if too few lanes passed.
module reversalmb_module #(
  parameter int PASS_THRESHOLD = 9,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_RX_SbMessage,
  input  logic        i_msg_valid,
  input  logic [15:0] i_RX_msg_data,
  input  logic        i_Busy_SideBand,
  input  logic        i_falling_edge_busy,
  input  logic        i_pattern_done,
  output logic [3:0]  o_TX_SbMessage,
  output logic        o_ValidOutDatat_REVERSALMB_Module,
  output logic        o_pattern_en,
  output logic        o_reversal_en,
  output logic        o_trainerror,
  output logic        o_MBINIT_REVERSALMB_end
);

  localparam logic [3:0] INIT_REQ  = 4'b0001;
  localparam logic [3:0] INIT_RSP  = 4'b0010;
  localparam logic [3:0] CLR_REQ   = 4'b0011;
  localparam logic [3:0] CLR_RSP   = 4'b0100;
  localparam logic [3:0] RES_REQ   = 4'b0101;
  localparam logic [3:0] RES_RSP   = 4'b0110;
  localparam logic [3:0] DONE_REQ  = 4'b0111;
  localparam logic [3:0] DONE_RSP  = 4'b1000;

  // The counter restarts at 0 on entry. Matching TIMEOUT_CYCLES-1 therefore
  // fires the ERROR edge exactly TIMEOUT_CYCLES cycles after entering the state.
  localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]  PASS_TH      = 6'(PASS_THRESHOLD);

  typedef enum logic [4:0] {
    IDLE,
    CHK_INIT, REQ_INIT, WAIT_INIT,
    CHK_CLR,  REQ_CLR,  WAIT_CLR,
    SEND_PAT,
    CHK_RES,  REQ_RES,  WAIT_RES,
    EVAL,
    CHK_DONE, REQ_DONE, WAIT_DONE,
    DONE,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        reversal_d;
  logic [4:0]  popcnt;
  logic        pass;
  logic        timed;
  logic        timeout;
  logic [3:0]  exp_rsp;
  logic        rsp_hit;
  logic [3:0]  tx_d;
  logic        valid_d, pat_d, err_d, end_d;

  // Count passing lanes in the latched result; only consulted in EVAL
  always_comb begin
    popcnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popcnt = popcnt + {4'd0, result_q[i]};
    end
  end

  assign pass = ({1'b0, popcnt} >= PASS_TH);

  // Response expected in the current WAIT state, plus the timed-state flag
  always_comb begin
    exp_rsp = 4'b0000;
    timed   = 1'b0;
    case (state_q)
      WAIT_INIT: begin exp_rsp = INIT_RSP; timed = 1'b1; end
      WAIT_CLR:  begin exp_rsp = CLR_RSP;  timed = 1'b1; end
      WAIT_RES:  begin exp_rsp = RES_RSP;  timed = 1'b1; end
      WAIT_DONE: begin exp_rsp = DONE_RSP; timed = 1'b1; end
      SEND_PAT:  begin timed = 1'b1; end
      default:   begin exp_rsp = 4'b0000; timed = 1'b0; end
    endcase
  end

  // A response matching the wrong state is simply not a hit (filtered).
  assign rsp_hit = timed && (state_q != SEND_PAT) && i_msg_valid &&
                   (i_RX_SbMessage == exp_rsp);
  assign timeout = timed && (cnt_q == TIMEOUT_LAST);

  // Next-state logic; abort has top priority, a response beats timeout
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    reversal_d = o_reversal_en;
    if (!i_start && (state_q != IDLE)) begin
      state_d    = IDLE;
      result_d   = 16'd0;
      reversal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:      if (i_start && !i_Busy_SideBand) state_d = CHK_INIT;
        CHK_INIT:  if (!i_Busy_SideBand) state_d = REQ_INIT;
        REQ_INIT:  if (i_falling_edge_busy) state_d = WAIT_INIT;
        WAIT_INIT: begin
          if (rsp_hit)      state_d = CHK_CLR;
          else if (timeout) state_d = ERROR;
        end
        CHK_CLR:   if (!i_Busy_SideBand) state_d = REQ_CLR;
        REQ_CLR:   if (i_falling_edge_busy) state_d = WAIT_CLR;
        WAIT_CLR: begin
          if (rsp_hit)      state_d = SEND_PAT;
          else if (timeout) state_d = ERROR;
        end
        SEND_PAT: begin
          if (i_pattern_done) state_d = CHK_RES;
          else if (timeout)   state_d = ERROR;
        end
        CHK_RES:   if (!i_Busy_SideBand) state_d = REQ_RES;
        REQ_RES:   if (i_falling_edge_busy) state_d = WAIT_RES;
        WAIT_RES: begin
          if (rsp_hit) begin
            result_d = i_RX_msg_data;
            state_d  = EVAL;
          end else if (timeout) begin
            state_d = ERROR;
          end
        end
        EVAL: begin
          if (pass) begin
            state_d = CHK_DONE;
          end else if (!o_reversal_en) begin
            // Single retry: reverse the lanes and redo clear-error + pattern.
            reversal_d = 1'b1;
            state_d    = CHK_CLR;
          end else begin
            state_d = ERROR;
          end
        end
        CHK_DONE:  if (!i_Busy_SideBand) state_d = REQ_DONE;
        REQ_DONE:  if (i_falling_edge_busy) state_d = WAIT_DONE;
        WAIT_DONE: begin
          if (rsp_hit)      state_d = DONE;
          else if (timeout) state_d = ERROR;
        end
        DONE:      state_d = DONE;
        ERROR:     state_d = ERROR;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Counter clears on every state change and only runs in timed states
  always_comb begin
    if ((state_d != state_q) || !timed) cnt_d = 11'd0;
    else                                cnt_d = cnt_q + 11'd1;
  end

  // Output decode from the next state so outputs move with the state register
  always_comb begin
    tx_d    = 4'b0000;
    valid_d = 1'b0;
    pat_d   = 1'b0;
    err_d   = 1'b0;
    end_d   = 1'b0;
    case (state_d)
      REQ_INIT: begin tx_d = INIT_REQ; valid_d = 1'b1; end
      REQ_CLR:  begin tx_d = CLR_REQ;  valid_d = 1'b1; end
      REQ_RES:  begin tx_d = RES_REQ;  valid_d = 1'b1; end
      REQ_DONE: begin tx_d = DONE_REQ; valid_d = 1'b1; end
      SEND_PAT: pat_d = 1'b1;
      DONE:     end_d = 1'b1;
      ERROR:    err_d = 1'b1;
      default:  tx_d = 4'b0000;
    endcase
  end

  // State, counter, latched result and registered outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q                           <= IDLE;
      cnt_q                             <= 11'd0;
      result_q                          <= 16'd0;
      o_TX_SbMessage                    <= 4'b0000;
      o_ValidOutDatat_REVERSALMB_Module <= 1'b0;
      o_pattern_en                      <= 1'b0;
      o_reversal_en                     <= 1'b0;
      o_trainerror                      <= 1'b0;
      o_MBINIT_REVERSALMB_end           <= 1'b0;
    end else begin
      state_q                           <= state_d;
      cnt_q                             <= cnt_d;
      result_q                          <= result_d;
      o_TX_SbMessage                    <= tx_d;
      o_ValidOutDatat_REVERSALMB_Module <= valid_d;
      o_pattern_en                      <= pat_d;
      o_reversal_en                     <= reversal_d;
      o_trainerror                      <= err_d;
      o_MBINIT_REVERSALMB_end           <= end_d;
    end
  end

endmodule
